// File: rtl/my_err_signal_gen_v1_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_err_signal_gen_v1_if
//  Description : Signal bundle for the modulation error-signal generator.
//                The master side drives control/sample inputs and observes
//                the results; the slave side is the generator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface my_err_signal_gen_v1_if #(
    parameter int ADC_BIT = 14
);
    logic                      i_status;
    logic                      i_polarity;
    logic                      i_trig;
    logic [31:0]               i_wait_cnt;
    logic signed [31:0]        i_err_offset;
    logic signed [ADC_BIT-1:0] i_adc_data;
    logic [31:0]               i_avg_sel;
    logic signed [31:0]        o_err;
    logic signed [31:0]        o_adc_sum;
    logic signed [31:0]        o_low_avg;
    logic signed [31:0]        o_high_avg;
    logic [3:0]                o_cstate;
    logic [3:0]                o_nstate;

    modport master (
        output i_status, i_polarity, i_trig, i_wait_cnt, i_err_offset,
               i_adc_data, i_avg_sel,
        input  o_err, o_adc_sum, o_low_avg, o_high_avg, o_cstate, o_nstate
    );

    modport slave (
        input  i_status, i_polarity, i_trig, i_wait_cnt, i_err_offset,
               i_adc_data, i_avg_sel,
        output o_err, o_adc_sum, o_low_avg, o_high_avg, o_cstate, o_nstate
    );
endinterface
`default_nettype wire

// File: rtl/my_err_signal_gen_v1.sv
`default_nettype none
// ============================================================================
//  Module      : my_err_signal_gen_v1
//  Description : Per half-period averaging of ADC samples with a settling
//                delay, producing high/low half averages and their signed,
//                offset-corrected difference as an error signal.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_err_signal_gen_v1 #(
    parameter int ADC_BIT = 14
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    my_err_signal_gen_v1_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WAIT   = 4'd1,
        S_ACCUM  = 4'd2,
        S_AVG    = 4'd3,
        S_UPDATE = 4'd4
    } state_t;

    localparam logic [4:0] c_K_MAX = 5'd16;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_wait_cnt;
    logic [16:0]        r_acc_cnt;
    logic [4:0]         r_k;
    logic               r_status;
    logic signed [31:0] r_acc;
    logic signed [31:0] r_err;
    logic signed [31:0] r_low_avg;
    logic signed [31:0] r_high_avg;

    logic [4:0]         w_k_sel;
    logic               w_wait_done;
    logic               w_acc_last;
    logic signed [31:0] w_adc_ext;
    logic signed [31:0] w_avg;
    logic               w_unused_avg_sel;

    // Only the low five bits select the averaging depth; cap at 2^16 samples.
    assign w_k_sel          = (bus.i_avg_sel[4:0] > c_K_MAX) ? c_K_MAX : bus.i_avg_sel[4:0];
    assign w_unused_avg_sel = &{1'b0, bus.i_avg_sel[31:5]};

    // A zero or one wait count both leave WAIT after a single cycle.
    assign w_wait_done = ({1'b0, r_wait_cnt} + 33'd1) >= {1'b0, bus.i_wait_cnt};
    assign w_acc_last  = (r_acc_cnt == ((17'd1 << r_k) - 17'd1));
    assign w_adc_ext   = {{(32-ADC_BIT){bus.i_adc_data[ADC_BIT-1]}}, bus.i_adc_data};
    assign w_avg       = r_acc >>> r_k;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a trigger restarts the measurement from any state.
    always_comb begin
        w_next = S_IDLE;
        if (bus.i_trig) begin
            w_next = S_WAIT;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_WAIT:   w_next = w_wait_done ? S_ACCUM : S_WAIT;
                S_ACCUM:  w_next = w_acc_last ? S_AVG : S_ACCUM;
                S_AVG:    w_next = S_UPDATE;
                S_UPDATE: w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Counters, accumulator, averages and the registered error result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_acc_cnt  <= '0;
            r_k        <= '0;
            r_status   <= 1'b0;
            r_acc      <= '0;
            r_err      <= '0;
            r_low_avg  <= '0;
            r_high_avg <= '0;
        end else if (bus.i_trig) begin
            r_wait_cnt <= '0;
            r_acc_cnt  <= '0;
            r_acc      <= '0;
            r_status   <= bus.i_status;
            r_k        <= w_k_sel;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (!w_wait_done) begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_adc_ext;
                    if (!w_acc_last) begin
                        r_acc_cnt <= r_acc_cnt + 17'd1;
                    end
                end
                S_AVG: begin
                    if (r_status) begin
                        r_high_avg <= w_avg;
                    end else begin
                        r_low_avg <= w_avg;
                    end
                end
                S_UPDATE: begin
                    if (bus.i_polarity) begin
                        r_err <= (r_high_avg - r_low_avg) - bus.i_err_offset;
                    end else begin
                        r_err <= (r_low_avg - r_high_avg) - bus.i_err_offset;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_err      = r_err;
    assign bus.o_adc_sum  = r_acc;
    assign bus.o_low_avg  = r_low_avg;
    assign bus.o_high_avg = r_high_avg;
    assign bus.o_cstate   = r_state;
    assign bus.o_nstate   = w_next;

endmodule
`default_nettype wire

// File: tb/tb_my_err_signal_gen_v1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_err_signal_gen_v1
//  Description : Directed bench for my_err_signal_gen_v1 with hand-computed
//                expected averages, error values and state timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_err_signal_gen_v1;

    localparam int c_PERIOD = 101;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    my_err_signal_gen_v1_if #(.ADC_BIT(14)) bus ();

    my_err_signal_gen_v1 #(.ADC_BIT(14)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Trigger is sampled on the next edge; returns one #1 after that edge.
    task automatic pulse_trig(input logic st);
        bus.i_trig   = 1'b1;
        bus.i_status = st;
        tick(1);
        bus.i_trig   = 1'b0;
    endtask

    task automatic run_half(input logic st);
        pulse_trig(st);
        tick(c_PERIOD - 1);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst              = 1'b1;
        bus.i_trig       = 1'b1;
        bus.i_status     = 1'b1;
        bus.i_polarity   = 1'b1;
        bus.i_wait_cnt   = 32'd10;
        bus.i_err_offset = 32'sd50;
        bus.i_adc_data   = 14'sd100;
        bus.i_avg_sel    = 32'd4;

        // Reset with trigger held high: trigger must be ignored.
        tick(2);
        check("rst_cstate", 32'(bus.o_cstate), 0);
        check("rst_err", bus.o_err, 0);
        check("rst_sum", bus.o_adc_sum, 0);
        check("rst_low", bus.o_low_avg, 0);
        check("rst_high", bus.o_high_avg, 0);
        rst        = 1'b0;
        bus.i_trig = 1'b0;
        tick(5);
        check("idle_cstate", 32'(bus.o_cstate), 0);
        check("idle_err", bus.o_err, 0);

        // Timing of one high half: wait=10, 16 samples of 100.
        pulse_trig(1'b1);
        check("t_e0_wait", 32'(bus.o_cstate), 1);
        tick(9);
        check("t_e9_wait", 32'(bus.o_cstate), 1);
        check("t_e9_nstate", 32'(bus.o_nstate), 2);
        tick(1);
        check("t_e10_accum", 32'(bus.o_cstate), 2);
        check("t_e10_sum", bus.o_adc_sum, 0);
        tick(1);
        check("t_e11_sum", bus.o_adc_sum, 100);
        tick(15);
        check("t_e26_avg", 32'(bus.o_cstate), 3);
        check("t_e26_sum", bus.o_adc_sum, 1600);
        tick(1);
        check("t_e27_update", 32'(bus.o_cstate), 4);
        check("t_e27_high", bus.o_high_avg, 100);
        check("t_e27_err_old", bus.o_err, 0);
        tick(1);
        check("t_e28_idle", 32'(bus.o_cstate), 0);
        check("t_e28_err", bus.o_err, 50);
        tick(72);
        check("t_hold_sum", bus.o_adc_sum, 1600);

        // Steady state.
        run_half(1'b0);
        check("st_low", bus.o_low_avg, 100);
        check("st_high", bus.o_high_avg, 100);
        check("st_err", bus.o_err, -50);
        run_half(1'b1);
        check("st_err2", bus.o_err, -50);

        // Step to -500.
        bus.i_adc_data = -14'sd500;
        run_half(1'b1);
        check("step_high", bus.o_high_avg, -500);
        check("step_low_held", bus.o_low_avg, 100);
        check("step_err", bus.o_err, -650);

        // Polarity 0: (100 - (-500)) - 50.
        bus.i_polarity = 1'b0;
        run_half(1'b1);
        check("pol_err", bus.o_err, 550);

        bus.i_polarity = 1'b1;
        run_half(1'b0);
        check("step_low", bus.o_low_avg, -500);
        check("step_err_low", bus.o_err, -50);
        check("step_sum", bus.o_adc_sum, -8000);

        // Abort during ACCUM.
        bus.i_adc_data = 14'sd7;
        pulse_trig(1'b1);
        tick(13);
        check("ab_accum", 32'(bus.o_cstate), 2);
        check("ab_sum_pre", bus.o_adc_sum, 21);
        pulse_trig(1'b0);
        check("ab_wait", 32'(bus.o_cstate), 1);
        check("ab_sum_clr", bus.o_adc_sum, 0);
        check("ab_high", bus.o_high_avg, -500);
        check("ab_low", bus.o_low_avg, -500);
        tick(28);
        check("ab_low_new", bus.o_low_avg, 7);
        check("ab_err_new", bus.o_err, -557);
        tick(72);

        // Zero wait, single sample (avg_sel low bits 0, upper bits ignored).
        bus.i_wait_cnt = 32'd0;
        bus.i_avg_sel  = 32'h0000_0020;
        bus.i_adc_data = -14'sd3;
        pulse_trig(1'b1);
        check("w0_e0_wait", 32'(bus.o_cstate), 1);
        tick(1);
        check("w0_e1_accum", 32'(bus.o_cstate), 2);
        tick(1);
        check("w0_e2_avg", 32'(bus.o_cstate), 3);
        check("w0_e2_sum", bus.o_adc_sum, -3);
        tick(2);
        check("w0_e4_idle", 32'(bus.o_cstate), 0);
        check("w0_high", bus.o_high_avg, -3);
        check("w0_err", bus.o_err, -60);
        tick(10);

        // k = 1 with junk in upper avg_sel bits: two samples of 9.
        bus.i_avg_sel  = 32'hFFFF_FFE1;
        bus.i_adc_data = 14'sd9;
        pulse_trig(1'b0);
        tick(10);
        check("k1_sum", bus.o_adc_sum, 18);
        check("k1_low", bus.o_low_avg, 9);
        check("k1_err", bus.o_err, -62);

        // Reset mid-measurement, trigger held during reset.
        pulse_trig(1'b1);
        tick(2);
        rst        = 1'b1;
        bus.i_trig = 1'b1;
        tick(1);
        check("mr_cstate", 32'(bus.o_cstate), 0);
        check("mr_sum", bus.o_adc_sum, 0);
        check("mr_err", bus.o_err, 0);
        check("mr_high", bus.o_high_avg, 0);
        check("mr_low", bus.o_low_avg, 0);
        tick(1);
        check("mr_cstate2", 32'(bus.o_cstate), 0);
        rst        = 1'b0;
        bus.i_trig = 1'b0;
        tick(3);
        check("mr_idle", 32'(bus.o_cstate), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
